// File: rtl/phase_sequencer_pkg.sv
// Shared encodings for the phase sequencer: FSM states, instruction classes
// and the extended opcodes that live in ir[7:4] of class-11 instructions.
package phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALTED  = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  localparam logic [3:0] OP_IN  = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_MEM    = 3;
  localparam int PH_WB     = 4;

  function automatic logic is_ext(input logic [1:0] cls, input logic [3:0] op,
                                  input logic [3:0] code);
    return (cls == CLS_ALU) && (op == code);
  endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Stall-cycle counter for handshake waits. at_limit flags that the current
// stalled cycle is the LIMIT-th one; LIMIT = 0 never flags.
module phase_sequencer_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);
  localparam bit HAS_LIMIT = (LIMIT != 0);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && HAS_LIMIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_limit = HAS_LIMIT && (cnt_q == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle control sequencer: decides when the datapath latches IR/PC,
// talks to memory and I/O, and counts retired instructions.
//   state   | meaning
//   IDLE    | waiting for run
//   FETCH   | memory read of next instruction, IR loads on mem_ready
//   DECODE  | single cycle; HLT advances PC and halts
//   EXEC    | one cycle, or I/O handshake wait for IN/OUT
//   MEM     | load/store handshake wait
//   WB      | register write, PC advance, retire
//   HALTED  | stopped after HLT, run resumes
//   ERROR   | handshake timeout, sticky until reset
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_mode,
  input  logic [15:0]      ir,
  input  logic             write_order,
  input  logic             mem_ready,
  input  logic             io_in_valid,
  input  logic             io_out_ready,
  output logic [4:0]       phase,
  output logic             ir_we,
  output logic             pc_we,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             reg_we,
  output logic             io_in_ack,
  output logic             io_out_valid,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             stall, at_limit, hs;
  logic [1:0]       cls;
  logic             op_in, op_out, op_hlt;
  logic             ir_unused;

  assign cls       = ir[15:14];
  assign op_in     = is_ext(cls, ir[7:4], OP_IN);
  assign op_out    = is_ext(cls, ir[7:4], OP_OUT);
  assign op_hlt    = is_ext(cls, ir[7:4], OP_HLT);
  assign ir_unused = ^{ir[13:8], ir[3:0]};

  // Any non-stalled cycle clears the timer, so every wait starts from zero.
  phase_sequencer_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (~stall),
    .en       (stall),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d      = state_q;
    retired_d    = retired_q;
    phase        = '0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    reg_we       = 1'b0;
    io_in_ack    = 1'b0;
    io_out_valid = 1'b0;
    halted       = 1'b0;
    timeout_err  = 1'b0;
    stall        = 1'b0;
    hs           = 1'b1;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        phase[PH_FETCH] = 1'b1;
        mem_req         = 1'b1;
        ir_we           = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
        else           stall   = 1'b1;
      end
      ST_DECODE: begin
        phase[PH_DECODE] = 1'b1;
        if (op_hlt) begin
          pc_we   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        phase[PH_EXEC] = 1'b1;
        if (op_in) begin
          io_in_ack = io_in_valid;
          hs        = io_in_valid;
        end else if (op_out) begin
          io_out_valid = 1'b1;
          hs           = io_out_ready;
        end
        if (hs) state_d = (cls == CLS_LD || cls == CLS_ST) ? ST_MEM : ST_WB;
        else    stall   = 1'b1;
      end
      ST_MEM: begin
        phase[PH_MEM] = 1'b1;
        mem_req       = 1'b1;
        mem_wr        = (cls == CLS_ST);
        if (mem_ready) state_d = ST_WB;
        else           stall   = 1'b1;
      end
      ST_WB: begin
        phase[PH_WB] = 1'b1;
        reg_we       = write_order;
        pc_we        = 1'b1;
        retired_d    = retired_q + 1'b1;
        state_d      = step_mode ? ST_IDLE : ST_FETCH;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (run) state_d = ST_FETCH;
      end
      ST_ERROR: timeout_err = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
    // A handshake in the limit cycle clears stall, so progress wins over timeout.
    if (stall && at_limit) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule
